// File: rtl/fsm_flow_ctrl_if.sv
// FIFO-bank status/flag bundle between the FIFO bank (master) and fsm_flow_ctrl (slave).
interface fsm_flow_ctrl_if #(
    parameter int unsigned NUM_FIFOS = 8,
    parameter int unsigned CNT_W     = 3
);
    logic [NUM_FIFOS-1:0]       empty;
    logic [NUM_FIFOS*CNT_W-1:0] fifo_cnt;
    logic [NUM_FIFOS-1:0]       fifo_error;
    logic [NUM_FIFOS-1:0]       almost_full;
    logic [NUM_FIFOS-1:0]       almost_empty;
    logic                       pause;
    logic [NUM_FIFOS-1:0]       error_fifo;

    modport master (
        output empty, fifo_cnt, fifo_error,
        input  almost_full, almost_empty, pause, error_fifo
    );

    modport slave (
        input  empty, fifo_cnt, fifo_error,
        output almost_full, almost_empty, pause, error_fifo
    );
endinterface

// File: rtl/fsm_flow_ctrl.sv
// Flow-control FSM for an N-channel FIFO bank: threshold config, idle/active tracking,
// per-FIFO almost-full/empty flags, global pause and sticky error capture.
module fsm_flow_ctrl #(
    parameter int unsigned NUM_FIFOS = 8,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [CNT_W-1:0] umbral_L,
    input  logic [CNT_W-1:0] umbral_H,
    fsm_flow_ctrl_if.slave   bus,
    output logic [2:0]       state,
    output logic [2:0]       next_state,
    output logic [CNT_W-1:0] umbral_L_out,
    output logic [CNT_W-1:0] umbral_H_out,
    output logic             idle_out,
    output logic             active_out,
    output logic             error_out
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'b000,
        ST_INIT   = 3'b001,
        ST_IDLE   = 3'b010,
        ST_ERROR  = 3'b011,
        ST_ACTIVE = 3'b100
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     umb_l_q, umb_l_d;
    logic [CNT_W-1:0]     umb_h_q, umb_h_d;
    logic [NUM_FIFOS-1:0] af_q, af_d;
    logic [NUM_FIFOS-1:0] ae_q, ae_d;
    logic                 pause_q, pause_d;
    logic [NUM_FIFOS-1:0] err_fifo_q, err_fifo_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            umb_l_q    <= '0;
            umb_h_q    <= '0;
            af_q       <= '0;
            ae_q       <= '0;
            pause_q    <= 1'b0;
            err_fifo_q <= '0;
        end else begin
            state_q    <= state_d;
            umb_l_q    <= umb_l_d;
            umb_h_q    <= umb_h_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            pause_q    <= pause_d;
            err_fifo_q <= err_fifo_d;
        end
    end

    // Next-state, threshold load, sticky errors and flag next-values
    always_comb begin
        state_d    = state_q;
        umb_l_d    = umb_l_q;
        umb_h_d    = umb_h_q;
        af_d       = '0;
        ae_d       = '0;
        err_fifo_d = err_fifo_q;

        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (!init) begin
                    umb_l_d = umbral_L;
                    umb_h_d = umbral_H;
                end else if (umb_l_q < umb_h_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                err_fifo_d = err_fifo_q | bus.fifo_error;
                if (|bus.fifo_error)  state_d = ST_ERROR;
                else if (&bus.empty)  state_d = ST_IDLE;
                else                  state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                err_fifo_d = err_fifo_q | bus.fifo_error;
                if (|bus.fifo_error)  state_d = ST_ERROR;
                else if (&bus.empty)  state_d = ST_IDLE;
                else                  state_d = ST_ACTIVE;
                for (int i = 0; i < int'(NUM_FIFOS); i++) begin
                    af_d[i] = (bus.fifo_cnt[i*CNT_W +: CNT_W] >= umb_h_q);
                    ae_d[i] = (bus.fifo_cnt[i*CNT_W +: CNT_W] <= umb_l_q);
                end
            end
            ST_ERROR: err_fifo_d = err_fifo_q | bus.fifo_error;
            default:  state_d = ST_RESET;
        endcase

        if (reset) state_d = ST_RESET;
        pause_d = |af_d;
    end

    assign state            = 3'(state_q);
    assign next_state       = 3'(state_d);
    assign umbral_L_out     = umb_l_q;
    assign umbral_H_out     = umb_h_q;
    assign idle_out         = (state_q == ST_IDLE);
    assign active_out       = (state_q == ST_ACTIVE);
    assign error_out        = (state_q == ST_ERROR);
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.pause        = pause_q;
    assign bus.error_fifo   = err_fifo_q;

endmodule

// File: tb/tb_fsm_flow_ctrl.sv
// Directed bench for fsm_flow_ctrl: configuration, activity flags, errors and resets.
module tb_fsm_flow_ctrl;
    localparam int unsigned NF = 8;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [CW-1:0] umbral_L, umbral_H;
    logic [2:0]    state, next_state;
    logic [CW-1:0] umbral_L_out, umbral_H_out;
    logic          idle_out, active_out, error_out;

    int n_run  = 0;
    int n_fail = 0;

    fsm_flow_ctrl_if #(.NUM_FIFOS(NF), .CNT_W(CW)) bus ();

    fsm_flow_ctrl #(.NUM_FIFOS(NF), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_L     (umbral_L),
        .umbral_H     (umbral_H),
        .bus          (bus.slave),
        .state        (state),
        .next_state   (next_state),
        .umbral_L_out (umbral_L_out),
        .umbral_H_out (umbral_H_out),
        .idle_out     (idle_out),
        .active_out   (active_out),
        .error_out    (error_out)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there after the rising edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [NF*CW-1:0] cnt_all(input logic [CW-1:0] v);
        logic [NF*CW-1:0] r;
        for (int i = 0; i < int'(NF); i++) r[i*CW +: CW] = v;
        return r;
    endfunction

    // Brings the block from anywhere to IDLE with thresholds l/h
    task automatic go_idle(input logic [CW-1:0] l, input logic [CW-1:0] h);
        reset = 1'b1; init = 1'b0; bus.fifo_error = '0; bus.empty = '1;
        tick();
        reset = 1'b0; tick();
        umbral_L = l; umbral_H = h; tick();
        init = 1'b1; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b0; umbral_L = '0; umbral_H = '0;
        bus.empty = '1; bus.fifo_cnt = '0; bus.fifo_error = '0;
        tick(); tick();
        n_run++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state got=%0h exp=0", state); end
        n_run++; if (next_state !== 3'd0) begin n_fail++; $display("FAIL rst_next got=%0h exp=0", next_state); end
        n_run++; if ({bus.almost_full, bus.almost_empty, bus.pause, bus.error_fifo} !== '0) begin n_fail++; $display("FAIL rst_flags af=%0h ae=%0h p=%0b ef=%0h exp=0", bus.almost_full, bus.almost_empty, bus.pause, bus.error_fifo); end
        n_run++; if ({umbral_L_out, umbral_H_out} !== 6'd0) begin n_fail++; $display("FAIL rst_umbral got=%0h/%0h exp=0/0", umbral_L_out, umbral_H_out); end
        reset = 1'b0; #1;
        n_run++; if (next_state !== 3'd1) begin n_fail++; $display("FAIL rst_rel_next got=%0h exp=1", next_state); end
        tick();
        n_run++; if (state !== 3'd1) begin n_fail++; $display("FAIL rst_to_init got=%0h exp=1", state); end
    endtask

    task automatic test_config();
        umbral_L = 3'd2; umbral_H = 3'd6; init = 1'b0;
        tick();
        n_run++; if ({umbral_L_out, umbral_H_out} !== {3'd2, 3'd6}) begin n_fail++; $display("FAIL cfg_load got=%0d/%0d exp=2/6", umbral_L_out, umbral_H_out); end
        n_run++; if (state !== 3'd1) begin n_fail++; $display("FAIL cfg_init got=%0h exp=1", state); end
        init = 1'b1; umbral_L = 3'd7; umbral_H = 3'd0; #1;
        n_run++; if (next_state !== 3'd2) begin n_fail++; $display("FAIL cfg_next got=%0h exp=2", next_state); end
        tick();
        n_run++; if (state !== 3'd2 || idle_out !== 1'b1) begin n_fail++; $display("FAIL cfg_idle state=%0h idle=%0b exp=2/1", state, idle_out); end
        n_run++; if ({umbral_L_out, umbral_H_out} !== {3'd2, 3'd6}) begin n_fail++; $display("FAIL cfg_hold got=%0d/%0d exp=2/6", umbral_L_out, umbral_H_out); end
    endtask

    task automatic test_invalid_config();
        reset = 1'b1; init = 1'b0; tick();
        reset = 1'b0; tick();
        umbral_L = 3'd5; umbral_H = 3'd5; tick();
        init = 1'b1; umbral_L = 3'd1; umbral_H = 3'd2; tick();
        n_run++; if (state !== 3'd1) begin n_fail++; $display("FAIL inv_stay got=%0h exp=1", state); end
        n_run++; if ({umbral_L_out, umbral_H_out} !== {3'd5, 3'd5}) begin n_fail++; $display("FAIL inv_noload got=%0d/%0d exp=5/5", umbral_L_out, umbral_H_out); end
        init = 1'b0; umbral_L = 3'd1; umbral_H = 3'd6; tick();
        init = 1'b1; tick();
        n_run++; if (state !== 3'd2) begin n_fail++; $display("FAIL inv_reload got=%0h exp=2", state); end
        n_run++; if (umbral_L_out !== 3'd1) begin n_fail++; $display("FAIL inv_l got=%0d exp=1", umbral_L_out); end
    endtask

    task automatic test_activity();
        logic [NF*CW-1:0] c;
        go_idle(3'd2, 3'd6);
        c = cnt_all(3'd3); c[2*CW +: CW] = 3'd6; bus.fifo_cnt = c;
        bus.empty = 8'hFF; tick();
        n_run++; if (state !== 3'd2) begin n_fail++; $display("FAIL act_idle got=%0h exp=2", state); end
        bus.empty = 8'hFB; #1;
        n_run++; if (next_state !== 3'd4) begin n_fail++; $display("FAIL act_next got=%0h exp=4", next_state); end
        tick();
        n_run++; if (state !== 3'd4 || active_out !== 1'b1 || bus.almost_full !== 8'h00) begin n_fail++; $display("FAIL act_enter state=%0h act=%0b af=%0h exp=4/1/0", state, active_out, bus.almost_full); end
        tick();
        n_run++; if (bus.almost_full !== 8'h04 || bus.pause !== 1'b1) begin n_fail++; $display("FAIL act_af af=%0h p=%0b exp=04/1", bus.almost_full, bus.pause); end
        n_run++; if (bus.almost_empty !== 8'h00) begin n_fail++; $display("FAIL act_ae0 got=%0h exp=00", bus.almost_empty); end
        c[2*CW +: CW] = 3'd1; bus.fifo_cnt = c; tick();
        n_run++; if (bus.almost_empty !== 8'h04 || bus.almost_full !== 8'h00 || bus.pause !== 1'b0) begin n_fail++; $display("FAIL act_ae ae=%0h af=%0h p=%0b exp=04/00/0", bus.almost_empty, bus.almost_full, bus.pause); end
        c[0 +: CW] = 3'd2; c[1*CW +: CW] = 3'd5; c[7*CW +: CW] = 3'd7; bus.fifo_cnt = c; tick();
        n_run++; if (bus.almost_empty !== 8'h05 || bus.almost_full !== 8'h80 || bus.pause !== 1'b1) begin n_fail++; $display("FAIL act_edges ae=%0h af=%0h p=%0b exp=05/80/1", bus.almost_empty, bus.almost_full, bus.pause); end
        bus.empty = 8'hFF; tick();
        n_run++; if (state !== 3'd2 || bus.almost_empty !== 8'h05) begin n_fail++; $display("FAIL act_back state=%0h ae=%0h exp=2/05", state, bus.almost_empty); end
        tick();
        n_run++; if ({bus.almost_full, bus.almost_empty, bus.pause} !== '0) begin n_fail++; $display("FAIL act_clear af=%0h ae=%0h p=%0b exp=0", bus.almost_full, bus.almost_empty, bus.pause); end
    endtask

    task automatic test_error();
        go_idle(3'd2, 3'd6);
        bus.fifo_cnt = cnt_all(3'd3); bus.empty = 8'hFB; tick();
        n_run++; if (state !== 3'd4) begin n_fail++; $display("FAIL err_pre got=%0h exp=4", state); end
        bus.fifo_error = 8'h20; bus.empty = 8'hFF; #1;
        n_run++; if (next_state !== 3'd3) begin n_fail++; $display("FAIL err_next got=%0h exp=3", next_state); end
        tick();
        n_run++; if (state !== 3'd3 || error_out !== 1'b1 || bus.error_fifo !== 8'h20) begin n_fail++; $display("FAIL err_enter state=%0h eo=%0b ef=%0h exp=3/1/20", state, error_out, bus.error_fifo); end
        bus.fifo_error = 8'h00; bus.empty = 8'h00; tick();
        n_run++; if (state !== 3'd3) begin n_fail++; $display("FAIL err_absorb got=%0h exp=3", state); end
        bus.fifo_error = 8'h01; bus.empty = 8'hFF; tick();
        n_run++; if (bus.error_fifo !== 8'h21 || state !== 3'd3) begin n_fail++; $display("FAIL err_sticky ef=%0h state=%0h exp=21/3", bus.error_fifo, state); end
        bus.fifo_error = 8'h00; reset = 1'b1; tick();
        n_run++; if (state !== 3'd0 || bus.error_fifo !== 8'h00) begin n_fail++; $display("FAIL err_reset state=%0h ef=%0h exp=0/00", state, bus.error_fifo); end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        go_idle(3'd2, 3'd6);
        bus.fifo_cnt = cnt_all(3'd7); bus.empty = 8'h00; tick(); tick();
        n_run++; if (bus.almost_full !== 8'hFF || bus.pause !== 1'b1) begin n_fail++; $display("FAIL mid_pre af=%0h p=%0b exp=FF/1", bus.almost_full, bus.pause); end
        reset = 1'b1; tick();
        n_run++; if (state !== 3'd0 || active_out !== 1'b0) begin n_fail++; $display("FAIL mid_state got=%0h act=%0b exp=0/0", state, active_out); end
        n_run++; if ({bus.almost_full, bus.almost_empty, bus.pause} !== '0) begin n_fail++; $display("FAIL mid_flags af=%0h ae=%0h p=%0b exp=0", bus.almost_full, bus.almost_empty, bus.pause); end
        n_run++; if ({umbral_L_out, umbral_H_out} !== 6'd0) begin n_fail++; $display("FAIL mid_umbral got=%0d/%0d exp=0/0", umbral_L_out, umbral_H_out); end
        reset = 1'b0;
    endtask

    task automatic test_error_in_init();
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        init = 1'b0; bus.fifo_error = 8'hFF; bus.empty = 8'h00; tick();
        n_run++; if (state !== 3'd1 || bus.error_fifo !== 8'h00) begin n_fail++; $display("FAIL init_err state=%0h ef=%0h exp=1/00", state, bus.error_fifo); end
        tick();
        n_run++; if (state !== 3'd1 || error_out !== 1'b0) begin n_fail++; $display("FAIL init_err2 state=%0h eo=%0b exp=1/0", state, error_out); end
        bus.fifo_error = 8'h00;
    endtask

    initial begin
        test_reset();
        test_config();
        test_invalid_config();
        test_activity();
        test_error();
        test_reset_mid();
        test_error_in_init();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
